// File: rtl/instr_decode_ctrl.sv
// instr_decode_ctrl: multicycle instruction register and FETCH/DECODE/EXEC/MEM/WB control FSM
// Ports: clk, reset_n (async active-low); instr_in/mem_ready/branch_taken from memory and ALU;
// ir_q and its opcode/rs/rt/rd fields, reg_dst_sel, ir_write/pc_write/mem_read/mem_write/reg_write strobes,
// state (FETCH=0..HALT=5) and halted.
module instr_decode_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr_in,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic [15:0] ir_q,
  output logic [3:0]  opcode,
  output logic [3:0]  rs_addr,
  output logic [3:0]  rt_addr,
  output logic [3:0]  rd_addr,
  output logic        reg_dst_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [2:0]  state,
  output logic        halted
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
  state_t st, nxt;
  assign opcode      = ir_q[15:12];
  assign rs_addr     = ir_q[11:8];
  assign rt_addr     = ir_q[7:4];
  assign rd_addr     = ir_q[3:0];
  assign reg_dst_sel = ~ir_q[15];
  assign state       = st;
  assign halted      = st == HALT;
  // Strobes are gated by reset_n so that nothing is issued while reset is held,
  // even though FETCH would otherwise request a read.
  always_comb begin
    nxt       = FETCH;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    if (reset_n)
      case (st)
        FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
          nxt      = mem_ready ? DECODE : FETCH;
        end
        DECODE: nxt = opcode == 4'hF ? HALT : EXEC;
        EXEC: begin
          pc_write = opcode == 4'hE && branch_taken;
          nxt      = opcode == 4'hE ? FETCH : (opcode == 4'hC || opcode == 4'hD) ? MEM : WB;
        end
        MEM: begin
          mem_read  = opcode == 4'hC;
          mem_write = opcode == 4'hD;
          nxt       = !mem_ready ? MEM : opcode == 4'hC ? WB : FETCH;
        end
        WB: reg_write = 1'b1;
        HALT: nxt = HALT;
        default: nxt = FETCH;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st   <= FETCH;
      ir_q <= '0;
    end else begin
      st <= nxt;
      if (ir_write) ir_q <= instr_in;
    end
endmodule

// File: tb/tb_instr_decode_ctrl.sv
// tb_instr_decode_ctrl: table-driven check of the instruction register and control FSM
module tb_instr_decode_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instr_in;
  logic        mem_ready;
  logic        branch_taken;
  logic [15:0] ir_q;
  logic [3:0]  opcode, rs_addr, rt_addr, rd_addr;
  logic        reg_dst_sel, ir_write, pc_write, mem_read, mem_write, reg_write, halted;
  logic [2:0]  state;
  int total = 0;
  int bad = 0;

  instr_decode_ctrl dut (
    .clk(clk), .reset_n(reset_n), .instr_in(instr_in), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .ir_q(ir_q), .opcode(opcode), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .reg_dst_sel(reg_dst_sel), .ir_write(ir_write),
    .pc_write(pc_write), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic [15:0] instr;
    logic        rdy;
    logic        br;
    logic [2:0]  st;
    logic [15:0] ir;
    logic [4:0]  strb;
    logic        hlt;
    logic        dst;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int step, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic chk_all(input int step, input vec_t v);
    chk("state", step, {13'd0, state}, {13'd0, v.st});
    chk("ir_q", step, ir_q, v.ir);
    chk("fields", step, {opcode, rs_addr, rt_addr, rd_addr}, v.ir);
    chk("strobes", step, {11'd0, ir_write, pc_write, mem_read, mem_write, reg_write}, {11'd0, v.strb});
    chk("halted", step, {15'd0, halted}, {15'd0, v.hlt});
    chk("reg_dst_sel", step, {15'd0, reg_dst_sel}, {15'd0, v.dst});
  endtask

  initial begin
    // strobe order: {ir_write, pc_write, mem_read, mem_write, reg_write}
    vq.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 5'b00000, 1'b0, 1'b1});
    vq.push_back('{1'b1, 16'h1234, 1'b1, 1'b0, 3'd0, 16'h0000, 5'b11100, 1'b0, 1'b1});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd1, 16'h1234, 5'b00000, 1'b0, 1'b1});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h1234, 5'b00000, 1'b0, 1'b1});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd4, 16'h1234, 5'b00001, 1'b0, 1'b1});
    vq.push_back('{1'b1, 16'h8567, 1'b1, 1'b0, 3'd0, 16'h1234, 5'b11100, 1'b0, 1'b1});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd1, 16'h8567, 5'b00000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h8567, 5'b00000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd4, 16'h8567, 5'b00001, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'hC123, 1'b0, 1'b0, 3'd0, 16'h8567, 5'b00100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'hC123, 1'b1, 1'b0, 3'd0, 16'h8567, 5'b11100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd1, 16'hC123, 5'b00000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd2, 16'hC123, 5'b00000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b0, 1'b0, 3'd3, 16'hC123, 5'b00100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b0, 1'b0, 3'd3, 16'hC123, 5'b00100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b0, 1'b0, 3'd3, 16'hC123, 5'b00100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd3, 16'hC123, 5'b00100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd4, 16'hC123, 5'b00001, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'hD000, 1'b1, 1'b0, 3'd0, 16'hC123, 5'b11100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd1, 16'hD000, 5'b00000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd2, 16'hD000, 5'b00000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd3, 16'hD000, 5'b00010, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'hE000, 1'b1, 1'b1, 3'd0, 16'hD000, 5'b11100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b1, 3'd1, 16'hE000, 5'b00000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b1, 3'd2, 16'hE000, 5'b01000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'hE000, 1'b1, 1'b0, 3'd0, 16'hE000, 5'b11100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd1, 16'hE000, 5'b00000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd2, 16'hE000, 5'b00000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h1234, 1'b1, 1'b0, 3'd0, 16'hE000, 5'b11100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd1, 16'h1234, 5'b00000, 1'b0, 1'b1});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h1234, 5'b00000, 1'b0, 1'b1});
    vq.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 5'b00000, 1'b0, 1'b1});
    vq.push_back('{1'b1, 16'hF000, 1'b1, 1'b0, 3'd0, 16'h0000, 5'b11100, 1'b0, 1'b1});
    vq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd1, 16'hF000, 5'b00000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h0000, 1'b0, 1'b0, 3'd5, 16'hF000, 5'b00000, 1'b1, 1'b0});
    reset_n = 1'b1;
    instr_in = '0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    #2 reset_n = 1'b0;
    foreach (vq[i]) begin
      @(negedge clk);
      reset_n = vq[i].rn;
      instr_in = vq[i].instr;
      mem_ready = vq[i].rdy;
      branch_taken = vq[i].br;
      #1 chk_all(i, vq[i]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_ready = i[0];
      branch_taken = ~i[0];
      instr_in = 16'($urandom);
      #1;
      chk("halt_state", 100 + i, {13'd0, state}, 16'd5);
      chk("halt_flag", 100 + i, {15'd0, halted}, 16'd1);
      chk("halt_strobes", 100 + i, {11'd0, ir_write, pc_write, mem_read, mem_write, reg_write}, 16'd0);
      chk("halt_ir", 100 + i, ir_q, 16'hF000);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_state", 200, {13'd0, state}, 16'd0);
    chk("rst_halted", 200, {15'd0, halted}, 16'd0);
    chk("rst_strobes", 200, {11'd0, ir_write, pc_write, mem_read, mem_write, reg_write}, 16'd0);
    chk("rst_ir", 200, ir_q, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("rel_mem_read", 201, {15'd0, mem_read}, 16'd1);
    chk("rel_state", 201, {13'd0, state}, 16'd0);
    @(negedge clk);
    #1;
    chk("wait_state", 202, {13'd0, state}, 16'd0);
    chk("wait_strobes", 202, {11'd0, ir_write, pc_write, mem_read, mem_write, reg_write}, 16'b00100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
